// File: rtl/text_area_pkg.sv
// Shared constants, FSM encoding and cursor operations for the text-area writer.
package text_area_pkg;

   localparam int unsigned COLS_DEF       = 80;
   localparam int unsigned ROWS_DEF       = 60;
   localparam int unsigned ROW_STRIDE_DEF = 128;
   localparam logic [15:0] BASE_DEF       = 16'd512;
   localparam logic [15:0] FILL_WORD_DEF  = 16'h0020;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;

   typedef enum logic [1:0] {CLR_ALL, IDLE, WRITE, CLR_ROW} wrState_e;

   typedef enum logic [2:0] {
      CUR_HOLD, CUR_INC, CUR_DEC, CUR_CR, CUR_NEWLINE, CUR_HOME
   } cursorOp_e;

endpackage

// File: rtl/text_area_writer_if.sv
// Character stream in, text-RAM write bus out; master modport is the writer side.
interface text_area_writer_if;

   logic        char_valid;
   logic        char_ready;
   logic [7:0]  char_data;
   logic [7:0]  char_color;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;

   modport master (
      input  char_valid, char_data, char_color,
      output char_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output char_valid, char_data, char_color,
      input  char_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/text_cursor.sv
// Terminal cursor: row/col registers with inc/dec/cr/newline/home and wrap flags.
module text_cursor
   import text_area_pkg::*;
#(
   parameter int unsigned COLS = COLS_DEF,
   parameter int unsigned ROWS = ROWS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  cursorOp_e  op,
   output logic [5:0] row,
   output logic [6:0] col,
   output logic       lastCol_c,
   output logic [5:0] nextRow_c
);

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   assign lastCol_c = (col == LAST_COL);
   assign nextRow_c = (row == LAST_ROW) ? 6'd0 : 6'(row + 6'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= 6'd0;
         col <= 7'd0;
      end else begin
         unique case (op)
            CUR_INC: begin
               // Advancing past the last column behaves like a newline
               if (lastCol_c) begin
                  col <= 7'd0;
                  row <= nextRow_c;
               end else begin
                  col <= 7'(col + 7'd1);
               end
            end
            CUR_DEC:     if (col != 7'd0) col <= 7'(col - 7'd1);
            CUR_CR:      col <= 7'd0;
            CUR_NEWLINE: begin
               col <= 7'd0;
               row <= nextRow_c;
            end
            CUR_HOME: begin
               col <= 7'd0;
               row <= 6'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/text_area_writer.sv
// Text-area RAM writer: clears the screen after reset, then prints characters at a cursor.
// Optional FORMFEED_CLEAR_EN: 0x0C clears the whole screen and homes the cursor.
module text_area_writer
   import text_area_pkg::*;
#(
   parameter int unsigned COLS       = COLS_DEF,
   parameter int unsigned ROWS       = ROWS_DEF,
   parameter int unsigned ROW_STRIDE = ROW_STRIDE_DEF,
   parameter logic [15:0] BASE       = BASE_DEF,
   parameter logic [15:0] FILL_WORD  = FILL_WORD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   text_area_writer_if.master bus,
   output logic [5:0]        cursor_row,
   output logic [6:0]        cursor_col,
   output logic              init_done
);

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   wrState_e   state;
   cursorOp_e  cursorOp;
   logic [5:0] clrRow;
   logic [6:0] clrCol;
   logic       pendNl;
   logic       accept;
   logic       isPrint;
   logic       clrAllLast;
   logic       lastCol_c;
   logic [5:0] nextRow_c;

   function automatic logic [15:0] cellAddr(input logic [5:0] r, input logic [6:0] c);
      return 16'(BASE + 16'(r) * 16'(ROW_STRIDE) + 16'(c));
   endfunction

   text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk       (clk),
      .rst       (rst),
      .op        (cursorOp),
      .row       (cursor_row),
      .col       (cursor_col),
      .lastCol_c (lastCol_c),
      .nextRow_c (nextRow_c)
   );

   // Character decode and the cursor move it implies at the accept edge
   always_comb begin
      cursorOp   = CUR_HOLD;
      accept     = bus.char_valid & bus.char_ready;
      isPrint    = (bus.char_data >= ASCII_SPACE) && (bus.char_data <= ASCII_TILDE);
      clrAllLast = (clrRow == LAST_ROW) && (clrCol == LAST_COL);
      if (accept) begin
         if (isPrint) begin
            cursorOp = CUR_INC;
         end else begin
            unique case (bus.char_data)
               ASCII_CR: cursorOp = CUR_CR;
               ASCII_LF: cursorOp = CUR_NEWLINE;
               ASCII_BS: cursorOp = CUR_DEC;
`ifdef FORMFEED_CLEAR_EN
               ASCII_FF: cursorOp = CUR_HOME;
`endif
               default:  cursorOp = CUR_HOLD;
            endcase
         end
      end
      if (state == CLR_ALL && bus.mem_we && clrAllLast) cursorOp = CUR_HOME;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= CLR_ALL;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= BASE;
         bus.mem_wdata  <= 16'd0;
         bus.char_ready <= 1'b0;
         init_done      <= 1'b0;
         clrRow         <= 6'd0;
         clrCol         <= 7'd0;
         pendNl         <= 1'b0;
      end else begin
         unique case (state)
            CLR_ALL: begin
               // mem_we low means the sweep has not started yet
               if (!bus.mem_we) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= BASE;
                  bus.mem_wdata <= FILL_WORD;
                  clrRow        <= 6'd0;
                  clrCol        <= 7'd0;
               end else if (clrAllLast) begin
                  bus.mem_we     <= 1'b0;
                  init_done      <= 1'b1;
                  bus.char_ready <= 1'b1;
                  state          <= IDLE;
               end else if (clrCol == LAST_COL) begin
                  clrCol       <= 7'd0;
                  clrRow       <= 6'(clrRow + 6'd1);
                  bus.mem_addr <= cellAddr(6'(clrRow + 6'd1), 7'd0);
               end else begin
                  clrCol       <= 7'(clrCol + 7'd1);
                  bus.mem_addr <= 16'(bus.mem_addr + 16'd1);
               end
            end
            IDLE: begin
               if (accept) begin
                  if (isPrint) begin
                     bus.mem_we     <= 1'b1;
                     bus.mem_addr   <= cellAddr(cursor_row, cursor_col);
                     bus.mem_wdata  <= {bus.char_color, bus.char_data};
                     pendNl         <= lastCol_c;
                     bus.char_ready <= 1'b0;
                     state          <= WRITE;
                  end else if (bus.char_data == ASCII_LF) begin
                     bus.mem_we     <= 1'b1;
                     bus.mem_addr   <= cellAddr(nextRow_c, 7'd0);
                     bus.mem_wdata  <= FILL_WORD;
                     clrCol         <= 7'd0;
                     bus.char_ready <= 1'b0;
                     state          <= CLR_ROW;
                  end else if (bus.char_data == ASCII_BS && cursor_col != 7'd0) begin
                     bus.mem_we     <= 1'b1;
                     bus.mem_addr   <= cellAddr(cursor_row, 7'(cursor_col - 7'd1));
                     bus.mem_wdata  <= FILL_WORD;
                     pendNl         <= 1'b0;
                     bus.char_ready <= 1'b0;
                     state          <= WRITE;
`ifdef FORMFEED_CLEAR_EN
                  end else if (bus.char_data == ASCII_FF) begin
                     bus.char_ready <= 1'b0;
                     state          <= CLR_ALL;
`endif
                  end
               end
            end
            WRITE: begin
               // Cursor has already moved to the new row when a wrap is pending
               if (pendNl) begin
                  bus.mem_addr  <= cellAddr(cursor_row, 7'd0);
                  bus.mem_wdata <= FILL_WORD;
                  clrCol        <= 7'd0;
                  state         <= CLR_ROW;
               end else begin
                  bus.mem_we     <= 1'b0;
                  bus.char_ready <= 1'b1;
                  state          <= IDLE;
               end
            end
            CLR_ROW: begin
               if (clrCol == LAST_COL) begin
                  bus.mem_we     <= 1'b0;
                  bus.char_ready <= 1'b1;
                  state          <= IDLE;
               end else begin
                  clrCol       <= 7'(clrCol + 7'd1);
                  bus.mem_addr <= 16'(bus.mem_addr + 16'd1);
               end
            end
            default: state <= CLR_ALL;
         endcase
      end
   end

endmodule

// File: tb/tb_text_area_writer.sv
// Directed self-checking bench for text_area_writer; honours FORMFEED_CLEAR_EN.
module tb_text_area_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] cursor_row;
   logic [6:0] cursor_col;
   logic       init_done;
   int         checks = 0;
   int         errors = 0;
   logic [31:0] wlog[$];

   text_area_writer_if bus();

   text_area_writer dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   // Every asserted write cycle is captured once as {addr, data}
   always @(negedge clk) if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_wdata});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitReady(input int bound);
      int n = 0;
      while (!bus.char_ready && n < bound) begin @(negedge clk); n++; end
      chk("ready_timeout", 32'(n < bound), 32'd1);
   endtask

   task automatic waitInit(input int bound);
      int n = 0;
      while (!init_done && n < bound) begin @(negedge clk); n++; end
      chk("init_timeout", 32'(n < bound), 32'd1);
   endtask

   // Presents one character and returns at the negedge after it was accepted
   task automatic sendChar(input logic [7:0] d, input logic [7:0] c);
      bus.char_data  = d;
      bus.char_color = c;
      bus.char_valid = 1'b1;
      waitReady(6000);
      @(negedge clk);
      bus.char_valid = 1'b0;
   endtask

   task automatic checkFullClear(input string tag);
      int bad = 0;
      logic [15:0] ea;
      chk({tag, "_count"}, 32'(wlog.size()), 32'd4800);
      foreach (wlog[i]) begin
         ea = 16'(512 + (i / 80) * 128 + (i % 80));
         if (wlog[i] !== {ea, 16'h0020}) bad++;
      end
      chk({tag, "_seq_bad"}, 32'(bad), 32'd0);
      if (wlog.size() == 4800) begin
         chk({tag, "_first"}, wlog[0], {16'd512, 16'h0020});
         chk({tag, "_last"}, wlog[4799], {16'd8143, 16'h0020});
      end
   endtask

   initial begin
      bus.char_valid = 1'b0;
      bus.char_data  = 8'h00;
      bus.char_color = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd512);
      chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_ready", 32'(bus.char_ready), 32'd0);
      chk("rst_init", 32'(init_done), 32'd0);
      chk("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);

      // Post-reset clear
      rst = 1'b0;
      waitInit(6000);
      checkFullClear("clr");
      chk("init_ready", 32'(bus.char_ready), 32'd1);
      chk("init_cursor", 32'({cursor_row, cursor_col}), 32'd0);

      // Single printable
      wlog.delete();
      sendChar(8'h41, 8'h1C);
      waitReady(100);
      chk("a_count", 32'(wlog.size()), 32'd1);
      if (wlog.size() > 0) chk("a_write", wlog[0], {16'd512, 16'h1C41});
      chk("a_cursor", 32'({cursor_row, cursor_col}), {19'd0, 6'd0, 7'd1});

      // CR: no write, column home; unknown code dropped
      wlog.delete();
      sendChar(8'h0D, 8'h00);
      sendChar(8'h01, 8'h00);
      @(negedge clk);
      chk("cr_nowrite", 32'(wlog.size()), 32'd0);
      chk("cr_cursor", 32'({cursor_row, cursor_col}), 32'd0);

      // Full row of 80 printables wraps and clears row 1
      for (int i = 0; i < 80; i++) sendChar(8'(8'h21 + 8'(i)), 8'h07);
      waitReady(200);
      chk("row_count", 32'(wlog.size()), 32'd160);
      if (wlog.size() >= 160) begin
         chk("row_first", wlog[0], {16'd512, 16'h0721});
         chk("row_lastchar", wlog[79], {16'd591, 16'h0770});
         chk("row_clr_first", wlog[80], {16'd640, 16'h0020});
         chk("row_clr_last", wlog[159], {16'd719, 16'h0020});
      end
      chk("row_cursor", 32'({cursor_row, cursor_col}), {19'd0, 6'd1, 7'd0});

      // Move to (59,5), then LF wraps to row 0 and clears it
      for (int i = 0; i < 58; i++) begin sendChar(8'h0A, 8'h00); waitReady(200); end
      for (int i = 0; i < 5; i++) sendChar(8'h58, 8'h02);
      waitReady(100);
      chk("pos59_cursor", 32'({cursor_row, cursor_col}), {19'd0, 6'd59, 7'd5});
      wlog.delete();
      sendChar(8'h0A, 8'h00);
      waitReady(200);
      chk("lfwrap_count", 32'(wlog.size()), 32'd80);
      if (wlog.size() >= 80) begin
         chk("lfwrap_first", wlog[0], {16'd512, 16'h0020});
         chk("lfwrap_last", wlog[79], {16'd591, 16'h0020});
      end
      chk("lfwrap_cursor", 32'({cursor_row, cursor_col}), 32'd0);

      // Backspace at (2,3) and at column 0
      sendChar(8'h0A, 8'h00); waitReady(200);
      sendChar(8'h0A, 8'h00); waitReady(200);
      for (int i = 0; i < 3; i++) sendChar(8'h59, 8'h03);
      waitReady(100);
      wlog.delete();
      sendChar(8'h08, 8'h00);
      waitReady(100);
      chk("bs_count", 32'(wlog.size()), 32'd1);
      if (wlog.size() > 0) chk("bs_write", wlog[0], {16'd770, 16'h0020});
      chk("bs_cursor", 32'({cursor_row, cursor_col}), {19'd0, 6'd2, 7'd2});
      sendChar(8'h0D, 8'h00);
      wlog.delete();
      sendChar(8'h08, 8'h00);
      @(negedge clk);
      chk("bs0_nowrite", 32'(wlog.size()), 32'd0);
      chk("bs0_cursor", 32'({cursor_row, cursor_col}), {19'd0, 6'd2, 7'd0});

      // Form feed
      sendChar(8'h5A, 8'h04);
      waitReady(100);
      wlog.delete();
      sendChar(8'h0C, 8'h00);
`ifdef FORMFEED_CLEAR_EN
      chk("ff_busy", 32'(bus.char_ready), 32'd0);
      waitReady(6000);
      checkFullClear("ff");
      chk("ff_cursor", 32'({cursor_row, cursor_col}), 32'd0);
      chk("ff_init", 32'(init_done), 32'd1);
`else
      chk("ff_ready", 32'(bus.char_ready), 32'd1);
      @(negedge clk);
      chk("ff_nowrite", 32'(wlog.size()), 32'd0);
      chk("ff_cursor", 32'({cursor_row, cursor_col}), {19'd0, 6'd2, 7'd1});
`endif

      // Reset in the middle of a row clear
      sendChar(8'h0A, 8'h00);
      repeat (10) @(negedge clk);
      chk("mid_we", 32'(bus.mem_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
      chk("mid_rst_init", 32'(init_done), 32'd0);
      chk("mid_rst_addr", 32'(bus.mem_addr), 32'd512);
      @(negedge clk);
      wlog.delete();
      rst = 1'b0;
      waitInit(6000);
      checkFullClear("reclr");
      chk("reclr_cursor", 32'({cursor_row, cursor_col}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
